// File: rtl/uart_lite_pkg.sv
// Shared definitions for the UART Lite register map: offsets, status layout, control bits.
// Also used by uart_lite_driver.
package uart_lite_pkg;

    localparam logic [3:0] UL_RX   = 4'h0;
    localparam logic [3:0] UL_TX   = 4'h4;
    localparam logic [3:0] UL_STAT = 4'h8;
    localparam logic [3:0] UL_CTRL = 4'hC;

    localparam int CTRL_RST_TX  = 0;
    localparam int CTRL_RST_RX  = 1;
    localparam int CTRL_INTR_EN = 4;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic overrun;
        logic intr_en;
        logic tx_full;
        logic tx_empty;
        logic rx_full;
        logic rx_valid;
    } uart_status_t;

endpackage

// File: rtl/uart_lite_axil_responder_byte_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; used for both RX and TX byte queues.
// A push into a full FIFO is taken only when a pop frees the slot in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Flush overrides any push or pop landing in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_lite_axil_responder.sv
// AXI4-Lite slave exposing the UART Lite register map, with bytes carried on AXI-Stream ports
// instead of a serial line. Holds the handshake regs, decode, STAT/CTRL and interrupt edge detect.
module uart_lite_axil_responder
    import uart_lite_pkg::*;
#(
    parameter int FIFO_DEPTH         = 16,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter bit RX_BACKPRESSURE    = 1'b0
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [7:0]                        s_axis_tdata,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [7:0]                        m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              interrupt
);
    localparam logic [1:0] SEL_RX   = UL_RX[3:2];
    localparam logic [1:0] SEL_TX   = UL_TX[3:2];
    localparam logic [1:0] SEL_STAT = UL_STAT[3:2];
    localparam logic [1:0] SEL_CTRL = UL_CTRL[3:2];
    localparam int         CW       = $clog2(FIFO_DEPTH) + 1;

    logic awready_q, awready_d, bvalid_q, bvalid_d;
    logic arready_q, arready_d, rvalid_q, rvalid_d;
    logic [7:0] rdata_q, rdata_d;
    logic overrun_q, overrun_d, intr_en_q, intr_en_d, irq_q, irq_d;
    logic rx_empty_prev_q, tx_empty_prev_q;

    logic wr_hs, rd_hs, ctrl_wr, tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
    logic [1:0] wr_sel, rd_sel;
    logic [7:0] rx_dout, tx_dout;
    logic rx_full, rx_empty, tx_full, tx_empty;
    logic [CW-1:0] rx_count, tx_count;
    uart_status_t stat;
    logic unused_bits;

    assign wr_hs    = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_hs    = arready_q && S_AXI_ARVALID;
    assign wr_sel   = S_AXI_AWADDR[3:2];
    assign rd_sel   = S_AXI_ARADDR[3:2];
    assign ctrl_wr  = wr_hs && (wr_sel == SEL_CTRL) && S_AXI_WSTRB[0];
    assign tx_push  = wr_hs && (wr_sel == SEL_TX) && S_AXI_WSTRB[0];
    assign tx_flush = ctrl_wr && S_AXI_WDATA[CTRL_RST_TX];
    assign rx_flush = ctrl_wr && S_AXI_WDATA[CTRL_RST_RX];
    assign rx_pop   = rd_hs && (rd_sel == SEL_RX);
    assign tx_pop   = m_axis_tvalid && m_axis_tready;

    assign s_axis_tready = RX_BACKPRESSURE ? !rx_full : 1'b1;
    assign rx_push       = s_axis_tvalid && s_axis_tready;
    assign m_axis_tvalid = !tx_empty;
    assign m_axis_tdata  = tx_dout;

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RDATA   = {{(C_S_AXI_DATA_WIDTH-8){1'b0}}, rdata_q};
    assign interrupt     = irq_q;

    assign unused_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_WSTRB, rx_count, tx_count};

    byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk(aclk), .rst(areset), .push(rx_push), .din(s_axis_tdata), .pop(rx_pop),
        .flush(rx_flush), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk(aclk), .rst(areset), .push(tx_push), .din(S_AXI_WDATA[7:0]), .pop(tx_pop),
        .flush(tx_flush), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    always_comb begin
        stat            = '0;
        stat.overrun    = overrun_q;
        stat.intr_en    = intr_en_q;
        stat.tx_full    = tx_full;
        stat.tx_empty   = tx_empty;
        stat.rx_full    = rx_full;
        stat.rx_valid   = !rx_empty;

        // Ready strobes are one-cycle pulses; a pending response blocks the next accept.
        awready_d = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
        arready_d = S_AXI_ARVALID && !rvalid_q && !arready_q;
        bvalid_d  = wr_hs || (bvalid_q && !S_AXI_BREADY);
        rvalid_d  = rd_hs || (rvalid_q && !S_AXI_RREADY);

        rdata_d = rdata_q;
        if (rd_hs) begin
            case (rd_sel)
                SEL_RX:   rdata_d = rx_empty ? 8'h00 : rx_dout;
                SEL_STAT: rdata_d = stat;
                default:  rdata_d = 8'h00;
            endcase
        end

        // A fresh overrun in the same cycle as a STAT read must not be lost.
        overrun_d = overrun_q;
        if (rd_hs && (rd_sel == SEL_STAT)) overrun_d = 1'b0;
        if (rx_push && rx_full && !rx_pop && !rx_flush) overrun_d = 1'b1;

        intr_en_d = ctrl_wr ? S_AXI_WDATA[CTRL_INTR_EN] : intr_en_q;
        irq_d     = intr_en_q && ((rx_empty_prev_q && !rx_empty) || (!tx_empty_prev_q && tx_empty));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            awready_q       <= 1'b0;
            bvalid_q        <= 1'b0;
            arready_q       <= 1'b0;
            rvalid_q        <= 1'b0;
            rdata_q         <= 8'h00;
            overrun_q       <= 1'b0;
            intr_en_q       <= 1'b0;
            irq_q           <= 1'b0;
            rx_empty_prev_q <= 1'b1;
            tx_empty_prev_q <= 1'b1;
        end else begin
            awready_q       <= awready_d;
            bvalid_q        <= bvalid_d;
            arready_q       <= arready_d;
            rvalid_q        <= rvalid_d;
            rdata_q         <= rdata_d;
            overrun_q       <= overrun_d;
            intr_en_q       <= intr_en_d;
            irq_q           <= irq_d;
            rx_empty_prev_q <= rx_empty;
            tx_empty_prev_q <= tx_empty;
        end
    end

endmodule

// File: tb/tb_uart_lite_axil_responder.sv
// Directed bench for uart_lite_axil_responder: register map, FIFOs, overrun, flush, interrupt
// pulses and response stalling, with hand-computed expected values.
module tb_uart_lite_axil_responder;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [3:0]  S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        interrupt;

    int n_assert = 0;
    int n_fail   = 0;
    int irq_cnt  = 0;

    always #5 aclk = ~aclk;

    uart_lite_axil_responder dut (
        .aclk(aclk), .areset(areset),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .interrupt(interrupt)
    );

    // Interrupt-high cycles; a correct pulse adds exactly one.
    always @(negedge aclk) if (!areset && interrupt) irq_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_aw();
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (S_AXI_AWREADY) break;
        end
        chk("awready", 32'(S_AXI_AWREADY), 32'h1);
        chk("wready", 32'(S_AXI_WREADY), 32'h1);
    endtask

    task automatic finish_b();
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (S_AXI_BVALID) break;
        end
        chk("bvalid", 32'(S_AXI_BVALID), 32'h1);
        chk("bresp", 32'(S_AXI_BRESP), 32'h0);
        S_AXI_BREADY = 1'b1;
        @(posedge aclk); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data);
        @(posedge aclk); #1;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        wait_aw();
        @(posedge aclk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        finish_b();
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        @(posedge aclk); #1;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (S_AXI_ARREADY) break;
        end
        chk("arready", 32'(S_AXI_ARREADY), 32'h1);
        @(posedge aclk); #1;
        S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (S_AXI_RVALID) break;
        end
        chk("rvalid", 32'(S_AXI_RVALID), 32'h1);
        chk("rresp", 32'(S_AXI_RRESP), 32'h0);
        data = S_AXI_RDATA;
        S_AXI_RREADY = 1'b1;
        @(posedge aclk); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(posedge aclk); #1;
        s_axis_tdata = b; s_axis_tvalid = 1'b1;
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  tx_seen [3];
        int          got;
        int          irq_base;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_awready", 32'(S_AXI_AWREADY), 32'h0);
        chk("rst_arready", 32'(S_AXI_ARREADY), 32'h0);
        chk("rst_bvalid", 32'(S_AXI_BVALID), 32'h0);
        chk("rst_rvalid", 32'(S_AXI_RVALID), 32'h0);
        chk("rst_rdata", S_AXI_RDATA, 32'h0);
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'h0);
        chk("rst_irq", 32'(interrupt), 32'h0);
        chk("rst_s_tready", 32'(s_axis_tready), 32'h1);
        @(posedge aclk); #1 areset = 1'b0;

        axi_read(4'h8, rd);  chk("stat_reset", rd, 32'h04);
        axi_read(4'h0, rd);  chk("rx_empty_read", rd, 32'h00);
        chk("irq_idle", 32'(irq_cnt), 32'h0);

        // RX byte with interrupts enabled
        axi_write(4'hC, 32'h10);
        rx_byte(8'h5A);
        repeat (3) @(posedge aclk);
        chk("irq_rx", 32'(irq_cnt), 32'h1);
        axi_read(4'h8, rd);  chk("stat_rx1", rd, 32'h15);
        axi_read(4'h0, rd);  chk("rx_5a", rd, 32'h5A);
        axi_read(4'h8, rd);  chk("stat_rx0", rd, 32'h14);

        // TX queue held by tready=0, then drained
        axi_write(4'hC, 32'h00);
        axi_read(4'h8, rd);  chk("stat_intr_off", rd, 32'h04);
        axi_write(4'h4, 32'h41);
        axi_write(4'h4, 32'h42);
        axi_write(4'h4, 32'h43);
        axi_read(4'h8, rd);  chk("stat_tx3", rd, 32'h00);
        chk("m_tvalid_fwft", 32'(m_axis_tvalid), 32'h1);
        chk("m_tdata_fwft", 32'(m_axis_tdata), 32'h41);
        axi_write(4'hC, 32'h10);
        irq_base = irq_cnt;
        @(posedge aclk); #1 m_axis_tready = 1'b1;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge aclk);
            if (m_axis_tvalid) begin
                if (got < 3) tx_seen[got] = m_axis_tdata;
                got++;
            end
        end
        @(posedge aclk); #1 m_axis_tready = 1'b0;
        chk("tx_count", 32'(got), 32'd3);
        chk("tx_b0", 32'(tx_seen[0]), 32'h41);
        chk("tx_b1", 32'(tx_seen[1]), 32'h42);
        chk("tx_b2", 32'(tx_seen[2]), 32'h43);
        chk("irq_tx", 32'(irq_cnt - irq_base), 32'h1);
        axi_read(4'h8, rd);  chk("stat_tx0", rd, 32'h14);

        // Overrun: 17 bytes into a 16-deep RX FIFO
        axi_write(4'hC, 32'h00);
        for (int i = 0; i < 17; i++) rx_byte(8'(i));
        axi_read(4'h8, rd);  chk("stat_overrun", rd, 32'h27);
        for (int i = 0; i < 16; i++) begin
            axi_read(4'h0, rd);
            chk("rx_seq", rd, 32'(i));
        end
        axi_read(4'h0, rd);  chk("rx_lost16", rd, 32'h00);
        axi_read(4'h8, rd);  chk("stat_ovr_clr", rd, 32'h04);

        // Full RX, then RX flush coincident with an incoming byte
        axi_write(4'hC, 32'h10);
        irq_base = irq_cnt;
        for (int i = 0; i < 16; i++) rx_byte(8'hA0 + 8'(i));
        repeat (3) @(posedge aclk);
        chk("irq_fill", 32'(irq_cnt - irq_base), 32'h1);
        axi_read(4'h8, rd);  chk("stat_full", rd, 32'h17);
        irq_base = irq_cnt;
        @(posedge aclk); #1;
        S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h12; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        wait_aw();
        s_axis_tdata = 8'hEE; s_axis_tvalid = 1'b1;
        @(posedge aclk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; s_axis_tvalid = 1'b0;
        finish_b();
        repeat (3) @(posedge aclk);
        chk("irq_flush", 32'(irq_cnt - irq_base), 32'h0);
        axi_read(4'h8, rd);  chk("stat_flush", rd, 32'h14);
        axi_read(4'h0, rd);  chk("rx_after_flush", rd, 32'h00);

        // Stalled write response with AW/W still asserted
        @(posedge aclk); #1;
        S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h99; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        wait_aw();
        @(posedge aclk);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("b_stall_valid", 32'(S_AXI_BVALID), 32'h1);
            chk("b_stall_noaw", 32'(S_AXI_AWREADY), 32'h0);
        end
        @(posedge aclk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
        @(posedge aclk); #1 S_AXI_BREADY = 1'b0;
        @(negedge aclk);
        chk("b_released", 32'(S_AXI_BVALID), 32'h0);
        chk("tx_99", 32'(m_axis_tdata), 32'h99);

        // Stalled read response with AR still asserted: exactly one pop
        rx_byte(8'h77);
        @(posedge aclk); #1;
        S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (S_AXI_ARREADY) break;
        end
        chk("ar_stall_hs", 32'(S_AXI_ARREADY), 32'h1);
        @(posedge aclk);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("r_stall_valid", 32'(S_AXI_RVALID), 32'h1);
            chk("r_stall_data", S_AXI_RDATA, 32'h77);
            chk("r_stall_noar", 32'(S_AXI_ARREADY), 32'h0);
        end
        @(posedge aclk); #1;
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
        @(posedge aclk); #1 S_AXI_RREADY = 1'b0;
        axi_read(4'h8, rd);  chk("stat_one_pop", rd, 32'h10);

        // Reset with queued data discards everything
        rx_byte(8'h33);
        @(posedge aclk); #1 areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        axi_read(4'h8, rd);  chk("stat_rereset", rd, 32'h04);
        axi_read(4'h0, rd);  chk("rx_rereset", rd, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
